// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding and default operand width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder shared by the serial datapath.
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, LSB first, one bit per clock; result registered on completion.
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the last result
//   RUN   | one operand bit added per edge, WIDTH edges total
//   DONE  | one-cycle done pulse, start ignored
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_cout;
    logic [WIDTH-1:0] res_shift;

    FA u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB; written with shifts so WIDTH=1 needs no special case.
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 scenarios plus a WIDTH=1 full-adder truth table.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_mis = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts one WIDTH=8 addition and watches 14 cycles; glitch_n>0 pulses start (with a=8'h11)
    // for the edge k+glitch_n, which must be ignored.
    task automatic run_add8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                            input logic c_v, input logic [7:0] exp_sum, input logic exp_cout,
                            input logic [7:0] hold_sum, input int glitch_n);
        int lat, busy_n, done_n;
        lat = 0; busy_n = 0; done_n = 0;
        @(negedge clk);
        a8 = a_v; b8 = b_v; cin8 = c_v; start8 = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 14; n++) begin
            start8 = (n == glitch_n);
            if (n == glitch_n) a8 = 8'h11;
            if (busy8) busy_n++;
            if (n == 4) check_val({tag, "_sum_hold"}, 32'(sum8), 32'(hold_sum));
            @(negedge clk);
            if (done8) begin
                done_n++;
                if (lat == 0) lat = n;
            end
        end
        start8 = 1'b0;
        check_val({tag, "_latency"}, lat, 8);
        check_val({tag, "_busy_cycles"}, busy_n, 8);
        check_val({tag, "_done_pulses"}, done_n, 1);
        check_val({tag, "_sum"}, 32'(sum8), 32'(exp_sum));
        check_val({tag, "_cout"}, 32'(cout8), 32'(exp_cout));
    endtask

    initial begin
        logic [7:0] fa_s_tab;
        logic [7:0] fa_c_tab;
        int t1, t2, done_seen;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy8), 0);
        check_val("rst_done", 32'(done8), 0);
        check_val("rst_sum", 32'(sum8), 0);
        check_val("rst_cout", 32'(cout8), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_add8("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 0);
        run_add8("ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 0);
        run_add8("a5_5a",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 0);
        run_add8("3c_0f",  8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 0);
        run_add8("ign_run",  8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8'h4B, 3);
        run_add8("ign_done", 8'h22, 8'h33, 1'b1, 8'h56, 1'b0, 8'h02, 9);

        // start held high: back-to-back operations spaced WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        t1 = 0; t2 = 0; done_seen = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done8) begin
                done_seen++;
                if (done_seen == 1) t1 = n;
                if (done_seen == 2) t2 = n;
            end
        end
        start8 = 1'b0;
        check_val("held_gap", t2 - t1, 10);
        check_val("held_sum", 32'(sum8), 32'h07);
        repeat (12) @(negedge clk);

        // reset in RUN cycle 4 aborts with outputs cleared immediately
        a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_rst_busy", 32'(busy8), 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy8), 0);
        check_val("mid_rst_done", 32'(done8), 0);
        check_val("mid_rst_sum", 32'(sum8), 0);
        check_val("mid_rst_cout", 32'(cout8), 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done8 || busy8) done_seen++;
        end
        check_val("abort_no_done", done_seen, 0);
        run_add8("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00, 0);

        // WIDTH=1 truth table, index {a,b,cin}
        fa_s_tab = 8'b1001_0110;
        fa_c_tab = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check_val($sformatf("w1_busy_%0d", i), 32'(busy1), 1);
            @(negedge clk);
            check_val($sformatf("w1_done_%0d", i), 32'(done1), 1);
            check_val($sformatf("w1_sum_%0d", i), 32'(sum1), 32'(fa_s_tab[i]));
            check_val($sformatf("w1_cout_%0d", i), 32'(cout1), 32'(fa_c_tab[i]));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide: a request to begin one addition.
REQ-005 Port a SHALL be an input, WIDTH bits wide: operand A, sampled only when start is accepted.
REQ-006 Port b SHALL be an input, WIDTH bits wide: operand B, sampled only when start is accepted.
REQ-007 Port cin SHALL be an input, 1 bit wide: carry-in, sampled only when start is accepted.
REQ-008 Port busy SHALL be an output, 1 bit wide: high while an addition is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: a one-cycle pulse that marks a completed result.
REQ-010 Port sum SHALL be an output, WIDTH bits wide: the registered result.
REQ-011 Port cout SHALL be an output, 1 bit wide: the registered carry-out.

Function
REQ-012 The block SHALL add a+b+cin bit-serially with one full adder, processing the LSB first and one bit per clock cycle.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at edge k SHALL be accepted as follows:
- a and b are loaded into internal shift registers;
- the carry flip-flop is loaded with cin;
- the bit counter is cleared;
- the FSM moves to RUN.
REQ-015 In RUN, each edge SHALL perform the following:
- shift both operand registers right by one;
- shift the full-adder S output into the MSB of the internal result register;
- load the carry flip-flop with Cout;
- increment the counter.
REQ-016 After exactly WIDTH RUN edges (edge k+WIDTH), the block SHALL:
- copy the internal result to sum;
- copy the carry flip-flop value to cout;
- move the FSM to DONE.
REQ-017 done SHALL be high only in DONE, which lasts exactly one cycle and then returns to IDLE.
REQ-018 Latency SHALL be: done is visible WIDTH cycles after the accepting edge.
REQ-019 Throughput SHALL be one addition every WIDTH+2 cycles at most.
REQ-020 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing, no restart and no error SHALL result.
REQ-022 sum and cout SHALL hold the last completed result through IDLE and the following RUN, and change only at the completion edge.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH in sum, with bit WIDTH of the true sum presented on cout.
REQ-024 When start is held high continuously, the block SHALL accept a new operation on the first IDLE cycle after each DONE.
REQ-025 For WIDTH=1, the block SHALL complete in one RUN cycle and reproduce the full-adder truth table.

Reset
REQ-026 Asserting rst SHALL immediately set the following, regardless of clk:
- FSM = IDLE;
- busy = 0, done = 0;
- sum = 0, cout = 0;
- counter, operand registers and carry flip-flop = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-028 The first start accepted after rst deasserts SHALL behave exactly as in REQ-014.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-030 The counter width SHALL be $clog2(WIDTH+1), computed locally.
REQ-031 The design SHALL contain exactly one sub-module instance: the team's existing full adder FA, with ports (A, B, Cin, S, Cout), fed from operand bit 0 and the carry flip-flop.
REQ-032 No other arithmetic operator SHALL be used on the datapath.

Verification
REQ-033 The bench SHALL cover these directed scenarios with WIDTH=8:
- a=8'h00, b=8'h00, cin=0 -> done after 8 cycles, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; busy high for exactly 8 cycles.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
- start pulsed with a=8'h11 in RUN while adding 8'h01+8'h01 -> result is 8'h02, single done pulse, 8'h11 never used.
- rst asserted in RUN cycle 4 -> all outputs 0 immediately, no done; then 8'h10+8'h20 -> sum=8'h30.
REQ-034 The bench SHALL run, with WIDTH=1, all 8 combinations of (a, b, cin) and check them against the full-adder truth table.
